regfile_sequencer: RTL and testbench

//  Initiator side of the register-file port: accepts one 16-bit instruction per handshake, decodes it,

---
 rtl/regfile_sequencer_pkg.sv | 53 +++++
 rtl/regfile_sequencer_if.sv | 37 +++
 rtl/regfile_sequencer_instr_decoder.sv | 40 ++++
 rtl/regfile_sequencer.sv | 113 +++++++++++
 tb/tb_regfile_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared constants for the register-file sequencer: instruction field positions,
// ALU opcodes, FSM state encoding and small decode helpers.
package regfile_sequencer_pkg;

  localparam int INSTR_WIDTH = 16;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int RDEST_HI = 11;
  localparam int RDEST_LO = 8;
  localparam int EXT_HI   = 7;
  localparam int EXT_LO   = 4;
  localparam int RSRC_HI  = 3;
  localparam int RSRC_LO  = 0;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  localparam logic [3:0] OP_REG = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV: legal = 1'b1;
      default:                                                legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Arithmetic and move ops take a signed immediate; logic ops take it unsigned.
  function automatic logic op_sign_extends(input logic [3:0] op);
    logic sext;
    case (op)
      OP_ADD, OP_SUB, OP_CMP, OP_MOV: sext = 1'b1;
      default:                        sext = 1'b0;
    endcase
    return sext;
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction, register-file and ALU signals of the sequencer; master is the
// sequencer's view, slave is the environment's view.
interface regfile_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
);

  logic                  InstrValid;
  logic [15:0]           Instr;
  logic                  InstrReady;
  logic [SEL_WIDTH-1:0]  SelectA;
  logic [SEL_WIDTH-1:0]  SelectB;
  logic [DATA_WIDTH-1:0] RegA;
  logic [DATA_WIDTH-1:0] RegB;
  logic [DATA_WIDTH-1:0] AluA;
  logic [DATA_WIDTH-1:0] AluB;
  logic [3:0]            AluOp;
  logic [DATA_WIDTH-1:0] AluResult;
  logic [SEL_WIDTH-1:0]  SelectInput;
  logic [DATA_WIDTH-1:0] In;
  logic                  WriteEnable;
  logic                  Retired;
  logic                  IllegalOp;

  modport master (
    input  InstrValid, Instr, RegA, RegB, AluResult,
    output InstrReady, SelectA, SelectB, AluA, AluB, AluOp,
           SelectInput, In, WriteEnable, Retired, IllegalOp
  );

  modport slave (
    output InstrValid, Instr, RegA, RegB, AluResult,
    input  InstrReady, SelectA, SelectB, AluA, AluB, AluOp,
           SelectInput, In, WriteEnable, Retired, IllegalOp
  );

endinterface

// File: rtl/regfile_sequencer_instr_decoder.sv
// Combinational instruction decode: ALU op, immediate selection and extension,
// write-back enable and illegal-op detection.
module regfile_sequencer_instr_decoder
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [3:0]            opcode,
  input  logic [7:0]            imm8,
  output logic [3:0]            alu_op,
  output logic                  use_imm,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic                  wb_en,
  output logic                  illegal
);

  // Register form carries its ALU op in the ext field (upper nibble of imm8).
  always_comb begin
    alu_op  = 4'h0;
    use_imm = 1'b0;
    imm_ext = {DATA_WIDTH{1'b0}};
    wb_en   = 1'b0;
    illegal = 1'b1;
    if (opcode == OP_REG) begin
      alu_op  = imm8[EXT_HI:EXT_LO];
      use_imm = 1'b0;
    end else begin
      alu_op  = opcode;
      use_imm = 1'b1;
    end
    if (op_sign_extends(alu_op)) begin
      imm_ext = {{(DATA_WIDTH-8){imm8[7]}}, imm8};
    end else begin
      imm_ext = {{(DATA_WIDTH-8){1'b0}}, imm8};
    end
    illegal = ~op_is_legal(alu_op);
    wb_en   = ~illegal & (alu_op != OP_CMP);
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: one instruction in flight through IDLE/READ/EXEC/WB,
// driving read selects, ALU operands and the write-back strobe.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
) (
  input logic                 Clock,
  input logic                 Reset,
  regfile_sequencer_if.master bus
);

  state_e                 state_r;
  state_e                 state_next_s;
  logic                   accept_s;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [3:0]             alu_op_r;
  logic [DATA_WIDTH-1:0]  result_r;
  logic                   instr_ready_r;
  logic                   write_enable_r;
  logic                   retired_r;
  logic                   illegal_op_r;

  logic [3:0]             dec_alu_op_s;
  logic                   dec_use_imm_s;
  logic [DATA_WIDTH-1:0]  dec_imm_ext_s;
  logic                   dec_wb_en_s;
  logic                   dec_illegal_s;

  regfile_sequencer_instr_decoder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_instr_decoder (
    .opcode  (instr_r[OPC_HI:OPC_LO]),
    .imm8    (instr_r[IMM_HI:IMM_LO]),
    .alu_op  (dec_alu_op_s),
    .use_imm (dec_use_imm_s),
    .imm_ext (dec_imm_ext_s),
    .wb_en   (dec_wb_en_s),
    .illegal (dec_illegal_s)
  );

  assign accept_s = (state_r == ST_IDLE) & bus.InstrValid;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: fixed four-cycle walk once an instruction is accepted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: state_next_s = ST_EXEC;
      ST_EXEC: state_next_s = ST_WB;
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Instruction latch, ALU op, result capture and the WB-cycle strobes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      instr_r        <= 16'h0000;
      alu_op_r       <= 4'h0;
      result_r       <= {DATA_WIDTH{1'b0}};
      instr_ready_r  <= 1'b1;
      write_enable_r <= 1'b0;
      retired_r      <= 1'b0;
      illegal_op_r   <= 1'b0;
    end else begin
      instr_ready_r <= (state_next_s == ST_IDLE);
      if (accept_s) begin
        instr_r <= bus.Instr;
      end
      if (state_r == ST_READ) begin
        alu_op_r <= dec_alu_op_s;
      end
      if (state_r == ST_EXEC) begin
        result_r <= bus.AluResult;
      end
      // Strobes are set on the EXEC->WB edge so they are high for exactly the WB cycle.
      write_enable_r <= (state_r == ST_EXEC) & dec_wb_en_s;
      retired_r      <= (state_r == ST_EXEC);
      illegal_op_r   <= (state_r == ST_EXEC) & dec_illegal_s;
    end
  end

  assign bus.InstrReady  = instr_ready_r;
  assign bus.SelectA     = SEL_WIDTH'(instr_r[RDEST_HI:RDEST_LO]);
  assign bus.SelectB     = SEL_WIDTH'(instr_r[RSRC_HI:RSRC_LO]);
  assign bus.SelectInput = SEL_WIDTH'(instr_r[RDEST_HI:RDEST_LO]);
  // RegA/RegB are already registered by the register file, so operands pass straight through.
  assign bus.AluA        = bus.RegA;
  assign bus.AluB        = dec_use_imm_s ? dec_imm_ext_s : bus.RegB;
  assign bus.AluOp       = alu_op_r;
  assign bus.In          = result_r;
  assign bus.WriteEnable = write_enable_r;
  assign bus.Retired     = retired_r;
  assign bus.IllegalOp   = illegal_op_r;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register-file model and reference ALU around the
// DUT, expected write-backs queued at issue and checked by a retire monitor.
module tb_regfile_sequencer;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic rf_clear = 1'b1;

  always #5 clk = ~clk;

  regfile_sequencer_if #(.DATA_WIDTH(16), .SEL_WIDTH(4)) bus ();

  regfile_sequencer #(.DATA_WIDTH(16), .SEL_WIDTH(4)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    bit          chk_data;
    logic        we;
    logic        ill;
    logic [3:0]  op;
    logic [15:0] alub;
    bit          chk_alub;
  } exp_t;

  exp_t        sb_q[$];
  int          acc_q[$];
  int          vectors   = 0;
  int          fails     = 0;
  int          cyc       = 0;
  int          acc_count = 0;
  int          prev_acc  = 0;
  int          acc_gap   = 0;
  logic [3:0]  exec_op   = 4'h0;
  logic [15:0] exec_alub = 16'h0000;
  logic [15:0] regs [16];
  exp_t        mon_e;
  int          lat;

  // Register file: registered reads, write on WriteEnable.
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else if (bus.WriteEnable) begin
      regs[bus.SelectInput] <= bus.In;
    end
    bus.RegA <= regs[bus.SelectA];
    bus.RegB <= regs[bus.SelectB];
  end

  // Reference ALU; CMP produces the difference.
  always_comb begin
    case (bus.AluOp)
      4'h1:    bus.AluResult = bus.AluA & bus.AluB;
      4'h2:    bus.AluResult = bus.AluA | bus.AluB;
      4'h3:    bus.AluResult = bus.AluA ^ bus.AluB;
      4'h5:    bus.AluResult = bus.AluA + bus.AluB;
      4'h9:    bus.AluResult = bus.AluA - bus.AluB;
      4'hB:    bus.AluResult = bus.AluA - bus.AluB;
      4'hD:    bus.AluResult = bus.AluB;
      default: bus.AluResult = 16'h0000;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Accept logger: cycle stamp of every handshake; in-flight work is discarded on reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      acc_q.delete();
    end else if (bus.InstrValid && bus.InstrReady) begin
      acc_q.push_back(cyc);
      acc_gap   <= cyc - prev_acc;
      prev_acc  <= cyc;
      acc_count <= acc_count + 1;
    end
  end

  // Retire monitor: EXEC-cycle operands are remembered one negedge back.
  always @(negedge clk) begin
    exec_op   <= bus.AluOp;
    exec_alub <= bus.AluB;
    if (!rst && bus.Retired) begin
      if (sb_q.size() == 0) begin
        check("unexpected_retire", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_select", 32'(bus.SelectInput), 32'(mon_e.sel));
        check("wb_we_illegal", {30'd0, bus.WriteEnable, bus.IllegalOp}, {30'd0, mon_e.we, mon_e.ill});
        check("exec_aluop", 32'(exec_op), 32'(mon_e.op));
        if (mon_e.chk_data) check("wb_data", 32'(bus.In), 32'(mon_e.data));
        if (mon_e.chk_alub) check("exec_alub", 32'(exec_alub), 32'(mon_e.alub));
        if (acc_q.size() == 0) begin
          lat = -1;
        end else begin
          lat = cyc - acc_q.pop_front();
        end
        check("latency", 32'(lat), 32'd3);
      end
    end
  end

  task automatic issue(input logic [15:0] ins);
    int c0 = acc_count;
    int n  = 0;
    @(negedge clk);
    bus.Instr      = ins;
    bus.InstrValid = 1'b1;
    while (acc_count == c0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.InstrValid = 1'b0;
    check("accepted", 32'(acc_count - c0), 32'd1);
  endtask

  task automatic expect_wb(input logic [3:0] sel, input logic [15:0] data, input bit chk_data,
                           input logic we, input logic ill, input logic [3:0] op,
                           input logic [15:0] alub, input bit chk_alub);
    exp_t e;
    e.sel = sel; e.data = data; e.chk_data = chk_data; e.we = we; e.ill = ill;
    e.op = op; e.alub = alub; e.chk_alub = chk_alub;
    sb_q.push_back(e);
  endtask

  task automatic run(input logic [15:0] ins, input logic [3:0] sel, input logic [15:0] data,
                     input logic we, input logic ill, input logic [3:0] op, input logic [15:0] alub);
    expect_wb(sel, data, 1'b1, we, ill, op, alub, 1'b1);
    issue(ins);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int c0;
    int n;
    bus.InstrValid = 1'b0;
    bus.Instr      = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready",   32'(bus.InstrReady),  32'd1);
    check("rst_we",      32'(bus.WriteEnable), 32'd0);
    check("rst_retired", 32'(bus.Retired),     32'd0);
    check("rst_illegal", 32'(bus.IllegalOp),   32'd0);
    check("rst_sel_in",  32'(bus.SelectInput), 32'd0);
    check("rst_in",      32'(bus.In),          32'd0);
    rst      = 1'b0;
    rf_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready_we", {30'd0, bus.InstrReady, bus.WriteEnable}, 32'd2);
    end

    // Load registers with MOV immediates (sign-extended).
    run(16'hD305, 4'd3, 16'h0005, 1'b1, 1'b0, 4'hD, 16'h0005);
    run(16'hD107, 4'd1, 16'h0007, 1'b1, 1'b0, 4'hD, 16'h0007);
    run(16'hD209, 4'd2, 16'h0009, 1'b1, 1'b0, 4'hD, 16'h0009);
    run(16'hD480, 4'd4, 16'hFF80, 1'b1, 1'b0, 4'hD, 16'hFF80);
    run(16'hD580, 4'd5, 16'hFF80, 1'b1, 1'b0, 4'hD, 16'hFF80);
    // ADDI R3,#-2: 5 + 0xFFFE
    run(16'h53FE, 4'd3, 16'h0003, 1'b1, 1'b0, 4'h5, 16'hFFFE);
    drain();

    // Register ADD R1,R2 twice with InstrValid held: 7+9, then 0x10+9.
    expect_wb(4'd1, 16'h0010, 1'b1, 1'b1, 1'b0, 4'h5, 16'h0009, 1'b1);
    expect_wb(4'd1, 16'h0019, 1'b1, 1'b1, 1'b0, 4'h5, 16'h0009, 1'b1);
    c0 = acc_count;
    n  = 0;
    @(negedge clk);
    bus.Instr      = 16'h0152;
    bus.InstrValid = 1'b1;
    while (acc_count < c0 + 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.InstrValid = 1'b0;
    check("held_accepts", 32'(acc_count - c0), 32'd2);
    check("accept_gap",   32'(acc_gap),         32'd4);
    drain();

    // ANDI R4,#FF zero-extends: 0xFF80 & 0x00FF.
    run(16'h14FF, 4'd4, 16'h0080, 1'b1, 1'b0, 4'h1, 16'h00FF);
    // CMP R4,R5: no write-back, result 0x0080 - 0xFF80.
    run(16'h04B5, 4'd4, 16'h0100, 1'b0, 1'b0, 4'hB, 16'hFF80);
    // Illegal ops.
    expect_wb(4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'hF, 16'h0000, 1'b0);
    issue(16'hF000);
    expect_wb(4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 1'b0);
    issue(16'h0000);
    // Register SUB R3,R2: 3 - 9.
    run(16'h0392, 4'd3, 16'hFFFA, 1'b1, 1'b0, 4'h9, 16'h0009);
    drain();

    // Reset in EXEC of ADDI R3,#1: nothing retires, R3 keeps 0xFFFA.
    issue(16'h5301);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.InstrReady),  32'd1);
    check("midrst_we",    32'(bus.WriteEnable), 32'd0);
    check("midrst_ret",   32'(bus.Retired),     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // ORI R3,#0 reads R3 back.
    run(16'h2300, 4'd3, 16'hFFFA, 1'b1, 1'b0, 4'h2, 16'h0000);
    // XORI R2,#0F: 9 ^ 0xF.
    run(16'h320F, 4'd2, 16'h0006, 1'b1, 1'b0, 4'h3, 16'h000F);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
